// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: symbol constants and scrambler LFSR helpers shared across the PHY transmit path.
package pcie_phy_pkg;
  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;
  localparam logic [7:0] STP_SYM = 8'hFB;
  localparam logic [7:0] SDP_SYM = 8'h5C;
  localparam logic [7:0] END_SYM = 8'hFD;
  localparam logic [7:0] EDB_SYM = 8'hFE;
  localparam logic [7:0] IDL_SYM = 8'h7C;
  localparam logic [7:0] FTS_SYM = 8'h3C;
  localparam logic [7:0] EIE_SYM = 8'hFC;
  localparam logic [15:0] LFSR_POLY = 16'h0039;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {SYM_COM, SYM_SKP, SYM_K, SYM_D} sym_kind_e;

  function automatic sym_kind_e classify(input logic k, input logic [7:0] s);
    return !k ? SYM_D : s == COM_SYM ? SYM_COM : s == SKP_SYM ? SYM_SKP : SYM_K;
  endfunction

  // Returns {lfsr after 8 Galois steps, keystream byte}; keystream bit 0 comes out first.
  function automatic logic [23:0] lfsr_byte(input logic [15:0] l);
    logic [7:0] ks;
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      ks[i] = l[15];
      l = {l[14:0], 1'b0} ^ (l[15] ? LFSR_POLY : 16'h0000);
    end
    return {l, ks};
  endfunction
endpackage

// File: rtl/scrambler_lfsr_lane.sv
// scrambler_lfsr_lane: one lane's LFSR, symbol decode and combinational scrambled symbol.
module scrambler_lfsr_lane
  import pcie_phy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       k_i,
  input  logic [7:0] sym_i,
  input  logic       bypass_i,
  output logic [7:0] sym_o
);
  logic [15:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [7:0] ks;
  sym_kind_e kind;
  always_comb begin
    kind = classify(k_i, sym_i);
    {lfsr_adv, ks} = lfsr_byte(lfsr_q);
    lfsr_d = !en_i ? lfsr_q : kind == SYM_COM ? LFSR_SEED : kind == SYM_SKP ? lfsr_q : lfsr_adv;
    sym_o = (kind == SYM_D && !bypass_i) ? sym_i ^ ks : sym_i;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
endmodule

// File: rtl/lane_scrambler.sv
// lane_scrambler: four independent lane scramblers with a one-cycle registered output stage.
module lane_scrambler
  import pcie_phy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic [7:0] data_3,
  input  logic [7:0] data_4,
  input  logic       k_1,
  input  logic       k_2,
  input  logic       k_3,
  input  logic       k_4,
  input  logic       os_bypass,
  input  logic       scr_disable,
  output logic       scr_valid,
  output logic [7:0] scr_data_1,
  output logic [7:0] scr_data_2,
  output logic [7:0] scr_data_3,
  output logic [7:0] scr_data_4,
  output logic       scr_k_1,
  output logic       scr_k_2,
  output logic       scr_k_3,
  output logic       scr_k_4
);
  logic [7:0] sym [4];
  logic [7:0] scr [4];
  logic [7:0] data_q [4];
  logic [3:0] k, k_q;
  logic valid_q;
  assign sym = '{data_1, data_2, data_3, data_4};
  assign k = {k_4, k_3, k_2, k_1};
  for (genvar i = 0; i < 4; i++) begin : g_lane
    scrambler_lfsr_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_i    (in_valid),
      .k_i     (k[i]),
      .sym_i   (sym[i]),
      .bypass_i(os_bypass | scr_disable),
      .sym_o   (scr[i])
    );
  end
  // Idle cycles drive zeros so the encoder never sees stale symbols.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q <= 1'b0;
      k_q <= 4'h0;
      data_q <= '{default: 8'h00};
    end else begin
      valid_q <= in_valid;
      k_q <= in_valid ? k : 4'h0;
      for (int j = 0; j < 4; j++) data_q[j] <= in_valid ? scr[j] : 8'h00;
    end
  assign scr_valid = valid_q;
  assign {scr_data_1, scr_data_2, scr_data_3, scr_data_4} = {data_q[0], data_q[1], data_q[2], data_q[3]};
  assign {scr_k_4, scr_k_3, scr_k_2, scr_k_1} = k_q;
endmodule

// File: tb/tb_lane_scrambler.sv
// tb_lane_scrambler: randomized and directed checks against a keystream-index reference model.
module tb_lane_scrambler;
  localparam int KS_N = 512;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, byp = 1'b0, dis = 1'b0;
  logic [7:0] d [4] = '{default: 8'h00};
  logic [3:0] kk = 4'h0;
  logic scr_valid;
  logic [7:0] q [4];
  logic [3:0] qk;
  logic [7:0] ks [KS_N];
  int idx [4] = '{default: 0};
  logic exp_v = 1'b0;
  logic [7:0] exp_d [4] = '{default: 8'h00};
  logic [3:0] exp_k = 4'h0;
  int n_cmp = 0, n_bad = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  lane_scrambler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .data_1(d[0]), .data_2(d[1]), .data_3(d[2]), .data_4(d[3]),
    .k_1(kk[0]), .k_2(kk[1]), .k_3(kk[2]), .k_4(kk[3]),
    .os_bypass(byp), .scr_disable(dis),
    .scr_valid(scr_valid),
    .scr_data_1(q[0]), .scr_data_2(q[1]), .scr_data_3(q[2]), .scr_data_4(q[3]),
    .scr_k_1(qk[0]), .scr_k_2(qk[1]), .scr_k_3(qk[2]), .scr_k_4(qk[3])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each lane tracks how many keystream bytes it has consumed since the last seed.
  always @(posedge clk or negedge rst)
    if (!rst) begin
      idx = '{default: 0};
      exp_v = 1'b0;
      exp_d = '{default: 8'h00};
      exp_k = 4'h0;
    end else begin
      exp_v = in_valid;
      for (int l = 0; l < 4; l++) begin
        exp_k[l] = in_valid & kk[l];
        exp_d[l] = 8'h00;
        if (in_valid) begin
          if (kk[l] && d[l] == 8'hBC) begin
            exp_d[l] = d[l];
            idx[l] = 0;
          end else if (kk[l] && d[l] == 8'h1C) exp_d[l] = d[l];
          else begin
            exp_d[l] = (kk[l] || byp || dis) ? d[l] : d[l] ^ ks[idx[l] % KS_N];
            idx[l]++;
          end
        end
      end
    end

  always @(negedge clk)
    if (run) chk("model", {scr_valid, qk, q[0], q[1], q[2], q[3]}, {exp_v, exp_k, exp_d[0], exp_d[1], exp_d[2], exp_d[3]});

  task automatic drive(input logic v, input logic [31:0] s, input logic [3:0] kv, input logic b, input logic ds);
    in_valid = v;
    {d[0], d[1], d[2], d[3]} = s;
    kk = kv;
    byp = b;
    dis = ds;
    @(negedge clk);
  endtask

  function automatic logic [31:0] lanes();
    return {q[0], q[1], q[2], q[3]};
  endfunction

  initial begin
    logic [15:0] l;
    logic [7:0] exp_seq [4];
    logic [7:0] kset [7];
    kset = '{8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h7C, 8'h3C, 8'hFC};
    exp_seq = '{8'hFF, 8'h17, 8'hC0, 8'h14};
    l = 16'hFFFF;
    for (int i = 0; i < KS_N; i++) begin
      ks[i] = 8'h00;
      for (int j = 0; j < 8; j++) begin
        ks[i][j] = l[15];
        l = ((l << 1) & 16'hFFFF) ^ (l[15] ? 16'h0039 : 16'h0000);
      end
    end
    #2 rst = 1'b0;
    @(negedge clk);
    run = 1'b1;
    chk("reset_out", {scr_valid, qk, lanes()}, 37'h0);
    rst = 1'b1;
    drive(1, {4{8'hBC}}, 4'hF, 0, 0);
    chk("com_out", {scr_valid, qk, lanes()}, {1'b1, 4'hF, {4{8'hBC}}});
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h0, 4'h0, 0, 0);
      chk($sformatf("ks_byte%0d", i), {qk, lanes()}, {4'h0, {4{exp_seq[i]}}});
    end
    drive(1, {4{8'hBC}}, 4'hF, 0, 0);
    drive(1, 32'h0, 4'h0, 0, 0);
    chk("skp_pre", lanes(), {4{8'hFF}});
    drive(1, {4{8'h1C}}, 4'hF, 0, 0);
    chk("skp_out", {qk, lanes()}, {4'hF, {4{8'h1C}}});
    drive(1, 32'h0, 4'h0, 0, 0);
    chk("skp_post", lanes(), {4{8'h17}});
    drive(1, {4{8'hBC}}, 4'hF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0, 4'h0, 1, 0);
      chk("bypass", lanes(), 32'h0);
    end
    drive(1, 32'h0, 4'h0, 0, 0);
    chk("bypass_adv", lanes(), {4{8'h14}});
    drive(1, {4{8'hBC}}, 4'hF, 0, 1);
    drive(1, {4{8'hFB}}, 4'hF, 0, 1);
    chk("stp_dis", {scr_valid, qk, lanes()}, {1'b1, 4'hF, {4{8'hFB}}});
    for (int i = 1; i <= 3; i++) begin
      drive(1, {4{i[7:0]}}, 4'h0, 0, 1);
      chk("dis_pass", {qk, lanes()}, {4'h0, {4{i[7:0]}}});
    end
    drive(0, 32'h0, 4'h0, 0, 0);
    chk("idle_zero", {scr_valid, qk, lanes()}, 37'h0);
    drive(1, {4{8'hBC}}, 4'hF, 0, 0);
    drive(1, 32'h0, 4'h0, 0, 0);
    drive(1, 32'hBC00_0000, 4'h1, 0, 0);
    chk("indep_mid", lanes(), {8'hBC, {3{8'h17}}});
    drive(1, 32'h0, 4'h0, 0, 0);
    chk("indep_post", lanes(), {8'hFF, {3{8'hC0}}});
    in_valid = 1'b1;
    {d[0], d[1], d[2], d[3]} = 32'h0;
    kk = 4'h0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_rst", {scr_valid, qk, lanes()}, 37'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'h0, 4'h0, 0, 0);
    chk("seed_restore", lanes(), {4{8'hFF}});
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom % 4) != 0;
      byp = ($urandom % 6) == 0;
      dis = ($urandom % 8) == 0;
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom % 16;
        if (idx[i] > KS_N - 8) r = 0;
        kk[i] = r < 4;
        d[i] = r == 0 ? 8'hBC : r == 1 ? 8'h1C : r < 4 ? kset[$urandom % 7] : 8'($urandom);
      end
      if (c == 1500) begin
        @(posedge clk);
        #3 rst = 1'b0;
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lane_scrambler.md
Name: lane_scrambler

Overview:
- Sits directly downstream of frame_generator in the PCIe PHY transmit path.
- Consumes the four per-lane symbols (data_1..data_4) each clock, plus per-lane K-symbol flags.
- Applies Gen1/Gen2 data scrambling with one LFSR per lane, polynomial x^16+x^5+x^4+x^3+1.
- Hands registered symbols and K flags to the 8b/10b encoder stage.

Parameters:
- LFSR_SEED, 16'hFFFF, LFSR value loaded on reset and after every COM.
- COM_SYM, 8'hBC, K28.5 byte value.
- SKP_SYM, 8'h1C, K28.0 byte value.

Ports:
- clk  input  1  transmit symbol clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  data_1..data_4 valid this cycle.
- data_1, data_2, data_3, data_4  input  8 each  lane 0..3 symbols from frame_generator.
- k_1, k_2, k_3, k_4  input  1 each  lane 0..3 symbol is a K character.
- os_bypass  input  1  D symbols this cycle belong to a TS1/TS2 ordered set; do not scramble them.
- scr_disable  input  1  LTSSM "disable scrambling"; pass data through unscrambled.
- scr_valid  output  1  outputs valid.
- scr_data_1, scr_data_2, scr_data_3, scr_data_4  output  8 each  scrambled lane symbols.
- scr_k_1, scr_k_2, scr_k_3, scr_k_4  output  1 each  K flags, delayed to align with the data.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous, active-low.
- Reset (rst=0):
  - All four LFSRs = LFSR_SEED.
  - scr_valid=0; all scr_data=8'h00; all scr_k=0.
  - Reset may assert at any cycle, including mid-packet. The next valid cycle after release restarts from seed.
- Latency:
  - Exactly 1 clock, with all outputs registered.
  - scr_valid(n+1) = in_valid(n).
  - scr_k_x(n+1) = k_x(n).
- When in_valid=0:
  - LFSRs hold.
  - scr_valid=0; scr_data and scr_k forced to 0.
- Per lane, per valid cycle, the symbol S with flag K takes one of four cases:
  - K=1 and S=COM_SYM: output S unscrambled. After the symbol, LFSR loads LFSR_SEED (no advance).
  - K=1 and S=SKP_SYM: output S unscrambled. LFSR holds.
  - K=1, any other K symbol (STP, SDP, END, EDB, IDL, FTS, EIE): output S unscrambled. LFSR advances 8 steps.
  - K=0 (data symbol): output S XOR keystream byte. LFSR advances 8 steps.
    - If os_bypass=1 or scr_disable=1, output S unchanged; LFSR still advances 8.
- LFSR step (Galois form), for step i=0..7 within a byte:
  - Keystream bit i = lfsr[15].
  - lfsr <= {lfsr[14:0],1'b0} XOR (lfsr[15] ? 16'h0039 : 0).
  - Keystream bit 0 XORs data bit 0 (LSB first).
- Lanes are fully independent: each LFSR acts only on its own lane's symbol and K flag.
- Simultaneous events:
  - scr_disable and os_bypass affect only D-symbol XOR, never LFSR sequencing.
  - COM wins over all bypass signals.
- scr_disable changing mid-stream takes effect the same cycle it is sampled; no resync is required.

Decomposition:
- Shared package pcie_phy_pkg holds:
  - K-symbol constants: COM 8'hBC, SKP 8'h1C, STP 8'hFB, SDP 8'h5C, END 8'hFD, EDB 8'hFE, IDL 8'h7C, FTS 8'h3C, EIE 8'hFC.
  - LFSR polynomial mask 16'h0039 and seed 16'hFFFF.
  - These are shared with frame_generator and the 8b/10b encoder.
- Sub-module scrambler_lfsr_lane holds one lane's LFSR state, 8-step next-state function, keystream byte and per-symbol control decode. It is instantiated 4 times.
- Top level adds the valid pipeline and output registers.

Test Plan:
- Reset, then COM on all lanes, then four cycles of D 8'h00 on all lanes -> outputs BC(K), FF, 17, C0, 14 on every lane, 1-cycle delayed.
- COM, D00, SKP, D00 on lane 0 -> FF then 1C(K) then 17. SKP neither advances the LFSR nor is scrambled.
- COM, then D00 with os_bypass=1 for 3 cycles, then D00 with os_bypass=0 -> 00,00,00,14. The LFSR advanced during the bypassed symbols.
- Frame from frame_generator: STP(K) then D 01,02,03 after COM, with scr_disable=1 -> bytes pass unchanged; scr_k aligned with data; scr_valid tracks in_valid by 1 cycle.
- Per-lane independence: lane 0 gets COM while lanes 1-3 get D00 mid-sequence -> lane 0 reseeds; lanes 1-3 continue their own keystreams.
- Assert rst mid-stream while in_valid=1 -> outputs 0 immediately (async). After release, D00 without COM -> FF (seed restored).
